// File: rtl/vip_frame_stream_gen.sv
// vip_frame_stream_gen: synthetic vsync/href/clken/Y frame source for the VIP pipeline.
// Optional LFSR noise pattern (mode 3) is built only when VIP_PATTERN_NOISE_EN is defined.
`default_nettype none

module vip_frame_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [1:0] mode,
    input  logic [7:0] level,
    output logic       busy,
    output logic       frame_done,
    output logic       pos_frame_vsync,
    output logic       pos_frame_href,
    output logic       pos_frame_clken,
    output logic [7:0] pos_img_Y
);

    localparam int XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int YW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [XW-1:0] c_X_MAX   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] c_H_BLANK = XW'(H_TOTAL - H_ACTIVE);
    localparam logic [YW-1:0] c_Y_MAX   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] c_V_BLANK = YW'(V_TOTAL - V_ACTIVE);
    localparam logic [DW-1:0] c_D_MAX   = DW'(CLK_DIV - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [DW-1:0] r_div;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_mode;
    logic [7:0]    r_level;
    logic          r_busy, r_vsync, r_href, r_clken, r_last, r_done;
    logic [7:0]    r_pix;

    logic          w_run, w_div_wrap, w_x_wrap, w_y_wrap, w_last;
    logic          w_vact, w_hact, w_clken, w_seed;
    logic [7:0]    w_ax;
    logic          w_ay3;
    logic [7:0]    w_pix;

    assign w_run      = (r_state == S_RUN);
    assign w_div_wrap = (r_div == c_D_MAX);
    assign w_x_wrap   = (r_x == c_X_MAX);
    assign w_y_wrap   = (r_y == c_Y_MAX);
    assign w_last     = w_run & w_div_wrap & w_x_wrap & w_y_wrap;
    assign w_vact     = (r_y >= c_V_BLANK);
    assign w_hact     = (r_x >= c_H_BLANK);
    assign w_clken    = (r_div == '0);
    assign w_ax       = 8'(r_x - c_H_BLANK);
    assign w_ay3      = 1'((r_y - c_V_BLANK) >> 3);
    // LFSR reseeds whenever a new frame is latched (fresh start or free-run restart)
    assign w_seed     = ((r_state == S_IDLE) & start) | (w_last & cont);

`ifdef VIP_PATTERN_NOISE_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 8'h01;
        end else if (w_seed) begin
            r_lfsr <= 8'h01;
        end else if (w_run & w_vact & w_hact & w_clken) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end
`endif

    always_comb begin
        w_pix = r_level;
        case (r_mode)
            2'd1:    w_pix = w_ax;
            2'd2:    w_pix = (w_ax[3] ^ w_ay3) ? 8'hFF : 8'h00;
`ifdef VIP_PATTERN_NOISE_EN
            2'd3:    w_pix = r_lfsr;
`endif
            default: w_pix = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_mode  <= 2'd0;
            r_level <= 8'h00;
            r_busy  <= 1'b0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_clken <= 1'b0;
            r_pix   <= 8'h00;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Output stage: one register behind the counters for every qualifier and Y
            r_busy  <= w_run;
            r_vsync <= w_run & w_vact;
            r_href  <= w_run & w_vact & w_hact;
            r_clken <= w_run & w_clken;
            r_pix   <= (w_run & w_vact & w_hact) ? w_pix : 8'h00;
            r_last  <= w_last;
            r_done  <= r_last;

            if (w_seed) begin
                r_mode  <= mode;
                r_level <= level;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_div   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                default: begin
                    if (w_div_wrap) begin
                        r_div <= '0;
                        if (w_x_wrap) begin
                            r_x <= '0;
                            r_y <= w_y_wrap ? '0 : r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                    if (w_last && !cont) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign frame_done      = r_done;
    assign pos_frame_vsync = r_vsync;
    assign pos_frame_href  = r_href;
    assign pos_frame_clken = r_clken;
    assign pos_img_Y       = r_pix;

endmodule

`default_nettype wire
